// File: rtl/servo_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// servo_ramp_ctrl
//
// Slew-rate-limited position sequencer feeding a multi-channel hobby-servo PWM
// block. Per-channel target/step commands arrive over a valid/ready handshake.
// Once per PWM frame a sweep walks every channel, one per clock, using a single
// shared subtract/compare/add datapath. Each sweep moves a channel's position
// toward its target by at most its step. A step of 0 jumps straight to target.
//
// Ports
//   clk50Mhz    in   1            system clock
//   rstn        in   1            asynchronous active-low reset
//   cmdValid    in   1            command present
//   cmdReady    out  1            command accepted when cmdValid && cmdReady
//   cmdIdx      in   IDX_W        target channel (>= NUM: consumed, ignored)
//   cmdPos      in   WIDTH        target position
//   cmdStep     in   WIDTH        max change per frame, 0 = jump
//   posArray    out  WIDTH*NUM    current positions, channel j at [WIDTH*j +: WIDTH]
//   atTarget    out  NUM          per-channel position == target
//   frameStart  out  1            one-cycle pulse on the first sweep cycle
// -----------------------------------------------------------------------------
module servo_ramp_ctrl #(
  parameter int WIDTH      = 16,
  parameter int NUM        = 4,
  parameter int IDX_W      = 2,
  parameter int FRAME_BITS = 20
) (
  input  logic                 clk50Mhz,
  input  logic                 rstn,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [IDX_W-1:0]     cmdIdx,
  input  logic [WIDTH-1:0]     cmdPos,
  input  logic [WIDTH-1:0]     cmdStep,
  output logic [WIDTH*NUM-1:0] posArray,
  output logic [NUM-1:0]       atTarget,
  output logic                 frameStart
);

  // Sweep index only has to count 0..NUM-1.
  localparam int SW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH-1:0] CENTRE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] r_frame_cnt;
  state_t                r_state;
  logic [SW-1:0]         r_idx;
  logic                  r_frame_start;
  logic [WIDTH-1:0]      r_pos    [NUM];
  logic [WIDTH-1:0]      r_target [NUM];
  logic [WIDTH-1:0]      r_step   [NUM];
  logic [NUM-1:0]        r_at_target;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic             w_tick;
  state_t           w_state_next;
  logic [SW-1:0]    w_idx_next;
  logic             w_frame_start_next;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_sweep;
  logic [WIDTH-1:0] w_cur_pos;
  logic [WIDTH-1:0] w_cur_tgt;
  logic [WIDTH-1:0] w_cur_step;
  logic             w_up;
  logic [WIDTH:0]   w_diff;
  logic             w_jump;
  logic [WIDTH-1:0] w_new_pos;

  // ---------------------------------------------------------------------------
  // Frame counter: free-running, tick on the all-ones count (PWM wrap point).
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk50Mhz or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_tick = &r_frame_cnt;

  // ---------------------------------------------------------------------------
  // Sweep FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50Mhz or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM: next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through the
  // case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_frame_start_next = 1'b0;
    w_cmd_ready        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Refuse commands on the tick cycle so none lands while a sweep starts.
        w_cmd_ready = !w_tick;
        if (w_tick) begin
          w_state_next       = S_UPDATE;
          w_idx_next         = '0;
          w_frame_start_next = 1'b1;
        end
      end
      S_UPDATE: begin
        if (r_idx == SW'(NUM - 1)) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  assign w_accept = cmdValid && w_cmd_ready;
  assign w_sweep  = (r_state == S_UPDATE);

  // ---------------------------------------------------------------------------
  // Shared datapath: select the channel under sweep, then apply the slew rule.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cur_pos  = '0;
    w_cur_tgt  = '0;
    w_cur_step = '0;
    for (int j = 0; j < NUM; j++) begin
      if (r_idx == SW'(j)) begin
        w_cur_pos  = r_pos[j];
        w_cur_tgt  = r_target[j];
        w_cur_step = r_step[j];
      end
    end
  end

  // Distance is taken one bit wider so the subtraction can never wrap. When the
  // distance exceeds the step, pos +/- step stays strictly between pos and
  // target, so the narrower result cannot overflow either.
  assign w_up      = (w_cur_tgt > w_cur_pos);
  assign w_diff    = w_up ? ({1'b0, w_cur_tgt} - {1'b0, w_cur_pos})
                          : ({1'b0, w_cur_pos} - {1'b0, w_cur_tgt});
  assign w_jump    = (w_cur_step == '0) || (w_diff <= {1'b0, w_cur_step});
  assign w_new_pos = w_jump ? w_cur_tgt
                   : (w_up ? (w_cur_pos + w_cur_step) : (w_cur_pos - w_cur_step));

  // ---------------------------------------------------------------------------
  // Per-channel state. Commands are only taken in IDLE and sweeps only run in
  // UPDATE, so the two write paths never collide on the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: these small register arrays are reset explicitly because the centred
  // power-up position is functional behaviour; a large RAM would not be.
  always_ff @(posedge clk50Mhz or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < NUM; j++) begin
        r_pos[j]    <= CENTRE;
        r_target[j] <= CENTRE;
        r_step[j]   <= '0;
      end
      r_at_target <= '1;
    end else begin
      for (int j = 0; j < NUM; j++) begin
        // An out-of-range cmdIdx matches no channel: consumed, no effect.
        if (w_accept && (cmdIdx == IDX_W'(j))) begin
          r_target[j]    <= cmdPos;
          r_step[j]      <= cmdStep;
          r_at_target[j] <= (r_pos[j] == cmdPos);
        end else if (w_sweep && (r_idx == SW'(j))) begin
          r_pos[j]       <= w_new_pos;
          r_at_target[j] <= (w_new_pos == w_cur_tgt);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM; g++) begin : g_pos_out
    assign posArray[WIDTH*g +: WIDTH] = r_pos[g];
  end

  assign atTarget   = r_at_target;
  assign frameStart = r_frame_start;
  assign cmdReady   = w_cmd_ready;

endmodule
